// File: rtl/univ_mod_counter.sv
// univ_mod_counter: up/down modulo-M counter with enable prescaler,
// synchronous clear, clamped parallel load, wrap or saturate boundary
// handling, terminal-count flags and a registered roll-over pulse.
module univ_mod_counter #(
  parameter int N     = 4,   // counter width in bits
  parameter int M     = 10,  // modulus, count range 0..M-1
  parameter int PRESC = 1,   // enable cycles per count step
  parameter int SAT   = 0    // 0 = wrap at the bounds, 1 = saturate
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         roll
);

  // Prescaler needs at least one bit even when every enable is a step.
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  // Top of the count range; M-1 always fits in N bits.
  localparam logic [N-1:0]  MAX_Q      = N'(M - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  logic [N-1:0]  cnt_p0;
  logic [PW-1:0] presc_p0;
  logic          roll_p0;

  logic [N-1:0]  cnt_next;
  logic [PW-1:0] presc_next;
  logic          roll_next;
  logic [N:0]    step_res;

  // Load values beyond the range settle at the top count.
  function automatic logic [N-1:0] clamp_load(input logic [N-1:0] v);
    clamp_load = (v > MAX_Q) ? MAX_Q : v;
  endfunction

  // Increment with boundary handling; result is {wrapped, next_count}.
  function automatic logic [N:0] step_up(input logic [N-1:0] v);
    if (v == MAX_Q) begin
      step_up = (SAT != 0) ? {1'b0, v} : {1'b1, {N{1'b0}}};
    end else begin
      step_up = {1'b0, v + 1'b1};
    end
  endfunction

  // Decrement with boundary handling; result is {wrapped, next_count}.
  function automatic logic [N:0] step_down(input logic [N-1:0] v);
    if (v == '0) begin
      step_down = (SAT != 0) ? {1'b0, v} : {1'b1, MAX_Q};
    end else begin
      step_down = {1'b0, v - 1'b1};
    end
  endfunction

  // Next-state selection: clear beats load beats enable; otherwise hold.
  // The roll pulse defaults low so it lasts exactly one cycle.
  always_comb begin
    cnt_next   = cnt_p0;
    presc_next = presc_p0;
    roll_next  = 1'b0;
    step_res   = {1'b0, cnt_p0};
    if (syn_clr) begin
      cnt_next   = '0;
      presc_next = '0;
    end else if (load) begin
      cnt_next   = clamp_load(d);
      presc_next = '0;
    end else if (en) begin
      if (presc_p0 == PRESC_LAST) begin
        // Prescaler phase complete: take one count step.
        presc_next = '0;
        step_res   = up ? step_up(cnt_p0) : step_down(cnt_p0);
        cnt_next   = step_res[N-1:0];
        roll_next  = step_res[N];
      end else begin
        presc_next = presc_p0 + 1'b1;
      end
    end
  end

  // State registers; reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p0   <= '0;
      presc_p0 <= '0;
      roll_p0  <= 1'b0;
    end else begin
      cnt_p0   <= cnt_next;
      presc_p0 <= presc_next;
      roll_p0  <= roll_next;
    end
  end

  assign q        = cnt_p0;
  assign max_tick = (cnt_p0 == MAX_Q);
  assign min_tick = (cnt_p0 == '0);
  assign roll     = roll_p0;

endmodule

// File: tb/tb_univ_mod_counter.sv
// Scoreboard bench for univ_mod_counter: four differently parametrised
// instances share one stimulus stream; a behavioural model queues the
// expected outputs and a monitor process compares them.
module tb_univ_mod_counter;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, syn_clr, load, en, up;
  logic [3:0] d;

  wire [3:0]    q0, q1, q2;
  wire [2:0]    q3;
  wire [NI-1:0] mx, mn, rl;

  univ_mod_counter #(.N(4), .M(10), .PRESC(1), .SAT(0)) u0 (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q0), .max_tick(mx[0]), .min_tick(mn[0]), .roll(rl[0]));
  univ_mod_counter #(.N(4), .M(10), .PRESC(1), .SAT(1)) u1 (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q1), .max_tick(mx[1]), .min_tick(mn[1]), .roll(rl[1]));
  univ_mod_counter #(.N(4), .M(10), .PRESC(3), .SAT(0)) u2 (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q2), .max_tick(mx[2]), .min_tick(mn[2]), .roll(rl[2]));
  univ_mod_counter #(.N(3), .M(8), .PRESC(2), .SAT(0)) u3 (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d[2:0]), .q(q3), .max_tick(mx[3]), .min_tick(mn[3]), .roll(rl[3]));

  typedef struct packed {
    logic [3:0] q;
    logic       mx;
    logic       mn;
    logic       rl;
  } obs_t;
  typedef obs_t [NI-1:0] obs_set_t;

  obs_set_t sb_q[$];

  int checks = 0;
  int fails  = 0;

  // Per-instance parameters and model state.
  int p_n[NI] = '{4, 4, 4, 3};
  int p_m[NI] = '{10, 10, 10, 8};
  int p_p[NI] = '{1, 1, 3, 2};
  int p_s[NI] = '{0, 1, 0, 0};
  int mq[NI];
  int mp[NI];
  int mr[NI];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mq[i] = 0;
      mp[i] = 0;
      mr[i] = 0;
    end
  endtask

  // Behavioural effect of one rising edge with the current inputs.
  task automatic model_edge();
    int dd;
    for (int i = 0; i < NI; i++) begin
      mr[i] = 0;
      if (!reset) begin
        mq[i] = 0;
        mp[i] = 0;
      end else if (syn_clr) begin
        mq[i] = 0;
        mp[i] = 0;
      end else if (load) begin
        dd = int'(d) % (1 << p_n[i]);
        mq[i] = (dd > p_m[i] - 1) ? p_m[i] - 1 : dd;
        mp[i] = 0;
      end else if (en) begin
        mp[i] = mp[i] + 1;
        if (mp[i] == p_p[i]) begin
          mp[i] = 0;
          if (up) begin
            if (mq[i] < p_m[i] - 1)  mq[i] = mq[i] + 1;
            else if (p_s[i] == 0) begin mq[i] = 0; mr[i] = 1; end
          end else begin
            if (mq[i] > 0)           mq[i] = mq[i] - 1;
            else if (p_s[i] == 0) begin mq[i] = p_m[i] - 1; mr[i] = 1; end
          end
        end
      end
    end
  endtask

  task automatic push_expect();
    obs_set_t e;
    for (int i = 0; i < NI; i++) begin
      e[i].q  = 4'(mq[i]);
      e[i].mx = (mq[i] == p_m[i] - 1);
      e[i].mn = (mq[i] == 0);
      e[i].rl = (mr[i] != 0);
    end
    sb_q.push_back(e);
  endtask

  // Drive inputs away from the active edge, queue the expectation, take the edge.
  task automatic step(input logic c, input logic l, input logic e, input logic u,
                      input logic [3:0] dv);
    @(negedge clk);
    syn_clr = c;
    load    = l;
    en      = e;
    up      = u;
    d       = dv;
    model_edge();
    push_expect();
    @(posedge clk);
  endtask

  // Called right after an edge: drop reset between clock edges.
  task automatic async_reset();
    #3;
    model_reset();
    push_expect();
    reset = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    syn_clr = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    reset   = 1'b1;
  endtask

  // Monitor: compare DUT outputs after every edge or reset assertion.
  initial begin
    obs_set_t e;
    obs_set_t act;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act[0] = {q0, mx[0], mn[0], rl[0]};
        act[1] = {q1, mx[1], mn[1], rl[1]};
        act[2] = {q2, mx[2], mn[2], rl[2]};
        act[3] = {1'b0, q3, mx[3], mn[3], rl[3]};
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("sb%0d_q", i),    32'(act[i].q),  32'(e[i].q));
          chk($sformatf("sb%0d_max", i),  32'(act[i].mx), 32'(e[i].mx));
          chk($sformatf("sb%0d_min", i),  32'(act[i].mn), 32'(e[i].mn));
          chk($sformatf("sb%0d_roll", i), 32'(act[i].rl), 32'(e[i].rl));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b0;
    syn_clr = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    up      = 1'b0;
    d       = '0;
    model_reset();
    #1;
    chk("rst_q", 32'(q0), 0);
    chk("rst_min", 32'(mn[0]), 1);
    chk("rst_max", 32'(mx[0]), 0);
    chk("rst_roll", 32'(rl[0]), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    release_reset();

    // Count up through the wrap.
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      #1;
      if (i == 9) chk("up_max9", 32'(mx[0]), 1);
      if (i == 10) begin
        chk("up_wrap_q", 32'(q0), 0);
        chk("up_wrap_roll", 32'(rl[0]), 1);
      end
      if (i == 11) chk("up_roll_once", 32'(rl[0]), 0);
    end
    chk("up_q12", 32'(q0), 2);
    chk("presc3_q12", 32'(q2), 4);

    // Load then count down through the wrap.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
    #1 chk("load3", 32'(q0), 3);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      #1;
      if (i == 3) chk("dn_min", 32'(mn[0]), 1);
      if (i == 4) begin
        chk("dn_wrap_q", 32'(q0), 9);
        chk("dn_wrap_roll", 32'(rl[0]), 1);
      end
    end
    chk("dn_q8", 32'(q0), 8);

    // Saturating instance.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      #1 chk("sat_no_roll", 32'(rl[1]), 0);
    end
    chk("sat_top", 32'(q1), 9);
    for (int i = 1; i <= 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    #1 chk("sat_bottom", 32'(q1), 0);

    // Prescaler phase freeze.
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    #1 chk("presc_q1", 32'(q2), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    #1 chk("presc_freeze", 32'(q2), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    #1 chk("presc_phase", 32'(q2), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    #1 chk("presc_q2", 32'(q2), 2);

    // Priority and load clamp.
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    #1 chk("prio_clr", 32'(q0), 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
    #1 chk("clamp_q0", 32'(q0), 9);
    chk("clamp_q3", 32'(q3), 7);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd4);
    #1 chk("load_over_en", 32'(q0), 4);

    // Asynchronous reset between edges.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd6);
    #1 chk("pre_async_q", 32'(q0), 6);
    async_reset();
    #1;
    chk("async_q", 32'(q0), 0);
    chk("async_roll", 32'(rl[0]), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    release_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    #1 chk("post_async_q", 32'(q0), 1);

    // Randomised traffic with occasional asynchronous resets.
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(15) == 0), 1'($urandom_range(7) == 0),
           1'($urandom_range(3) != 0), 1'($urandom_range(1)),
           4'($urandom_range(15)));
      if ($urandom_range(99) == 0) begin
        async_reset();
        step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b1, 4'd0);
        release_reset();
      end
    end

    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/univ_mod_counter.md
Name: univ_mod_counter

Overview:
Parametrised up/down modulo-M counter with a built-in enable prescaler. It supports synchronous clear, parallel load, and wrap or saturate mode, and provides terminal-count flags plus a registered roll-over pulse. It is the general-purpose successor to the free-running binary counter. Timer, baud-tick and sequencing logic instantiate it wherever a counter with control inputs is needed.

Parameters:
N, 4, counter width in bits; N >= 1.
M, 10, modulus; count range is 0..M-1; 2 <= M <= 2**N.
PRESC, 1, prescale ratio; the count steps once per PRESC qualifying enable cycles; PRESC >= 1.
SAT, 0, boundary mode; 0 = wrap at the bounds, 1 = saturate at the bounds.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous reset, active-low; clears all state immediately while low.
syn_clr  input  1  synchronous clear of the count and the prescaler.
load  input  1  synchronous parallel load from d.
en  input  1  count enable.
up  input  1  direction; 1 = increment, 0 = decrement.
d  input  N  load value.
q  output  N  current count (registered).
max_tick  output  1  combinational; high when q == M-1.
min_tick  output  1  combinational; high when q == 0.
roll  output  1  registered one-cycle pulse; high in the cycle after the count wrapped.

Behaviour:
- Reset (reset low, asynchronous): q = 0, prescaler count = 0, roll = 0. Consequently min_tick = 1 and max_tick = 0 during reset.
- Per-edge priority when reset is high: syn_clr > load > en > hold.
- syn_clr: q <= 0; prescaler <= 0; roll <= 0.
- load: q <= d if d <= M-1, otherwise q <= M-1 (clamped). Prescaler <= 0. roll <= 0.
- Prescaler: internal counter of width clog2(PRESC), minimum 1 bit.
  - Increments only on edges where en=1 and neither syn_clr nor load is asserted.
  - When the prescaler equals PRESC-1 on such an edge, a "step" occurs and the prescaler returns to 0.
  - With PRESC = 1, every enabled edge is a step.
- Step with up=1:
  - q < M-1: q <= q+1.
  - q == M-1, SAT=0: q <= 0 and roll <= 1.
  - q == M-1, SAT=1: q holds and roll stays 0.
- Step with up=0:
  - q > 0: q <= q-1.
  - q == 0, SAT=0: q <= M-1 and roll <= 1.
  - q == 0, SAT=1: q holds.
- roll is 1 for exactly one cycle after a wrap step and is 0 on every other edge, including hold, clear and load edges.
- en=0: q and the prescaler hold; roll <= 0.
- Direction change: a change of up takes effect on the next step. The prescaler phase is not reset by a direction change.
- Arithmetic: compare against M-1 at N-bit width (M-1 always fits in N bits). No intermediate result may exceed N bits. When M == 2**N the wrap behaviour equals natural N-bit overflow.
- Reset asserted mid-count (reset low at any time): state clears immediately, without waiting for clk. Counting resumes on the first enabled edge after reset returns high; the prescaler restarts from 0.
- Out-of-range state is unreachable from reset, clear or load, so no recovery logic is required.

Test Plan:
- Defaults (N=4, M=10, PRESC=1, SAT=0): release reset, en=1, up=1 for 12 edges -> q = 1..9, 0, 1, 2. max_tick is high while q=9. roll is high in the single cycle q=0 after 9.
- Defaults: load with d=3, then up=0, en=1 for 5 edges -> q = 3, 2, 1, 0, 9, 8. roll pulses once, when q becomes 9. min_tick is high while q=0.
- SAT=1: load d=7, up=1, en=1 for 5 edges -> q = 8, 9, 9, 9, 9 and roll is never asserted. Then up=0 for 12 edges -> q reaches 0 and holds there.
- PRESC=3: en=1, up=1 -> q increments on every third edge (0,0,0,1,1,1,2...). Dropping en for 2 cycles mid-phase freezes both q and the prescaler phase.
- Priority and clamp: syn_clr=1, load=1, en=1 together -> q=0. load=1 with d=15 -> q=9. load=1, en=1, d=4 -> q=4 (no increment).
- Asynchronous reset: with q=6, pull reset low between clock edges -> q=0 and roll=0 immediately. Release reset, en=1 -> first step gives q=1.
